async_fifo_wr_ctrl: RTL and testbench

//  Write-domain controller of the dual-clock FIFO; pairs with the read-domain controller.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_ptr_sync.sv | 34 +++
 rtl/async_fifo_wr_ctrl.sv | 90 +++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for both controllers of the dual-clock FIFO.
//  - MAX_W      : widest pointer the conversion helpers handle
//  - fifo_depth : number of RAM entries for a given address width
//  - bin2gray / gray2bin : width-generic conversions. Callers zero-extend
//    their pointer to MAX_W and size-cast the result back. Zero upper bits
//    pass through both conversions unchanged, so the low bits are exact.
package fifo_pkg;

  localparam int MAX_W = 32;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
    logic [MAX_W-1:0] bin;
    bin[MAX_W-1] = gray[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
//  clk, rst : destination clock and its async active-high reset
//  d        : Gray pointer from the source domain
//  q        : synchronised pointer (last stage)
// Only one bit of d changes per source increment, so a capture that lands
// mid-transition resolves to either the old or the new pointer.
module fifo_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO.
//  W_CLK, W_RST    : write clock, async active-high reset
//  wr_inc          : write request this cycle
//  gray_rd_ptr     : read pointer (Gray) from the read domain
//  wr_en, wr_addr  : strobe/address for the shared dual-port RAM
//  gray_wr_ptr     : registered Gray write pointer to the read domain
//  wr_full, wr_almost_full, wr_level : registered status
//  wr_overflow     : sticky, set by a request while full, cleared by reset
// Handshake: wr_inc is a request, ~wr_full is the ready. A write is
// accepted on a W_CLK edge exactly when wr_en (= wr_inc & ~wr_full) is high;
// a request while full is dropped, not held.
// ADDR_WIDTH must be at least 2 for the full comparison below.
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  wr_inc,
  input  logic [ADDR_WIDTH:0]   gray_rd_ptr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   gray_wr_ptr,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] gray_nxt;
  logic [PW-1:0] rd_sync;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] full_pattern;
  logic [PW-1:0] level_nxt;

  fifo_ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (W_CLK),
    .rst (W_RST),
    .d   (gray_rd_ptr),
    .q   (rd_sync)
  );

  // Acceptance uses the registered full flag, so a read pointer arriving in
  // the same cycle as a request while full does not rescue that request.
  // W_RST also gates the strobe so nothing reaches the RAM during reset.
  always_comb begin
    wr_en        = wr_inc & ~wr_full & ~W_RST;
    wr_ptr_nxt   = wr_ptr + {{(PW-1){1'b0}}, wr_en};
    gray_nxt     = PW'(bin2gray(MAX_W'(wr_ptr_nxt)));
    rd_bin       = PW'(gray2bin(MAX_W'(rd_sync)));
    // Full in Gray space: writer is one lap ahead, which shows up as the two
    // top bits inverted and the rest equal.
    full_pattern = {~rd_sync[PW-1:PW-2], rd_sync[PW-3:0]};
    // Modular subtraction keeps the level correct across pointer wrap.
    level_nxt    = wr_ptr_nxt - rd_bin;
  end

  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      wr_ptr         <= '0;
      gray_wr_ptr    <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_level       <= '0;
      wr_overflow    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      gray_wr_ptr    <= gray_nxt;
      wr_full        <= (gray_nxt == full_pattern);
      wr_almost_full <= (level_nxt >= AF_THRESH);
      wr_level       <= level_nxt;
      wr_overflow    <= wr_overflow | (wr_inc & wr_full);
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
module tb_async_fifo_wr_ctrl;

  logic       W_CLK;
  logic       W_RST;
  logic       wr_inc;
  logic [3:0] gray_rd_ptr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] gray_wr_ptr;
  logic       wr_full;
  logic       wr_almost_full;
  logic [3:0] wr_level;
  logic       wr_overflow;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] gold_gray [8];
  logic [3:0] exp_val;
  int unsigned m_wr;

  async_fifo_wr_ctrl #(
    .ADDR_WIDTH  (3),
    .SYNC_STAGES (2),
    .AF_MARGIN   (2)
  ) dut (
    .W_CLK          (W_CLK),
    .W_RST          (W_RST),
    .wr_inc         (wr_inc),
    .gray_rd_ptr    (gray_rd_ptr),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .gray_wr_ptr    (gray_wr_ptr),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  // clock / reset
  initial W_CLK = 1'b0;
  always #5 W_CLK = ~W_CLK;

  // model helper: 4-bit Gray of a binary count
  function automatic logic [3:0] g4(input int unsigned b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  task automatic pop_exp(output logic [3:0] v);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no entry required one");
      v = 'x;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    W_RST = 1'b1; wr_inc = 1'b0; gray_rd_ptr = 4'b0000;
    tick(); tick();
    W_RST = 1'b0;
    checks++;
    if ({gray_wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow, wr_addr} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: got gray=%b full=%b af=%b lvl=%0d ovf=%b addr=%0d required all 0",
               gray_wr_ptr, wr_full, wr_almost_full, wr_level, wr_overflow, wr_addr);
    end
    for (int i = 0; i < 2; i++) begin
      wr_inc = 1'b1;
      exp_q.push_back(g4(i + 1));
      tick();
      wr_inc = 1'b0;
      pop_exp(exp_val);
      checks++;
      if (gray_wr_ptr !== exp_val) begin
        errors++;
        $display("FAIL pre_reset_gray: got %b required %b", gray_wr_ptr, exp_val);
      end
    end
    checks++;
    if (wr_level !== 4'd2) begin
      errors++;
      $display("FAIL pre_reset_level: got %0d required 2", wr_level);
    end
    // mid-cycle pulse, released before the next edge
    #2 W_RST = 1'b1;
    #1;
    checks++;
    if ({gray_wr_ptr, wr_level, wr_addr, wr_full, wr_almost_full, wr_overflow} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset: got gray=%b lvl=%0d addr=%0d required 0", gray_wr_ptr, wr_level, wr_addr);
    end
    #1 W_RST = 1'b0;
    tick();
    checks++;
    if (gray_wr_ptr !== 4'b0000 || wr_level !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got gray=%b lvl=%0d required 0000/0", gray_wr_ptr, wr_level);
    end
    m_wr = 0;
  endtask

  // eight back-to-back writes into an empty FIFO with the reader at 0
  task automatic test_fill();
    gray_rd_ptr = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      wr_inc = 1'b1;
      #1;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'(i)) begin
        errors++;
        $display("FAIL fill_strobe[%0d]: got en=%b addr=%0d required 1/%0d", i, wr_en, wr_addr, i);
      end
      exp_q.push_back(gold_gray[i]);
      tick();
      pop_exp(exp_val);
      checks++;
      if (gray_wr_ptr !== exp_val) begin
        errors++;
        $display("FAIL fill_gray[%0d]: got %b required %b", i, gray_wr_ptr, exp_val);
      end
      checks++;
      if (wr_level !== 4'(i + 1) || wr_almost_full !== (i >= 5) || wr_full !== (i == 7)) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got lvl=%0d af=%b full=%b required lvl=%0d af=%b full=%b",
                 i, wr_level, wr_almost_full, wr_full, i + 1, (i >= 5), (i == 7));
      end
    end
    wr_inc = 1'b0;
    m_wr = 8;
  endtask

  task automatic test_overflow();
    wr_inc = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_strobe: got en=%b required 0", wr_en);
    end
    tick();
    wr_inc = 1'b0;
    checks++;
    if (gray_wr_ptr !== 4'b1100 || wr_overflow !== 1'b1 || wr_full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got gray=%b ovf=%b full=%b required 1100/1/1", gray_wr_ptr, wr_overflow, wr_full);
    end
    tick(); tick();
    checks++;
    if (wr_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", wr_overflow);
    end
  endtask

  task automatic test_drain();
    gray_rd_ptr = 4'b0010;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (e < 3 && (wr_full !== 1'b1 || wr_level !== 4'd8)) begin
        errors++;
        $display("FAIL drain_early[%0d]: got full=%b lvl=%0d required 1/8", e, wr_full, wr_level);
      end else if (e == 3 && (wr_full !== 1'b0 || wr_level !== 4'd5 || wr_almost_full !== 1'b0)) begin
        errors++;
        $display("FAIL drain_seen: got full=%b lvl=%0d af=%b required 0/5/0", wr_full, wr_level, wr_almost_full);
      end
    end
  endtask

  task automatic test_wrap();
    int wraps;
    logic [3:0] prev;
    wraps = 0;
    gray_rd_ptr = g4(m_wr - 2);
    tick(); tick(); tick();
    checks++;
    if (wr_level !== 4'd2) begin
      errors++;
      $display("FAIL wrap_start_level: got %0d required 2", wr_level);
    end
    for (int n = 0; n < 40; n++) begin
      prev = gray_wr_ptr;
      wr_inc = 1'b1;
      exp_q.push_back(g4(m_wr + 1));
      tick();
      wr_inc = 1'b0;
      m_wr++;
      pop_exp(exp_val);
      checks++;
      if (gray_wr_ptr !== exp_val) begin
        errors++;
        $display("FAIL wrap_gray[%0d]: got %b required %b", n, gray_wr_ptr, exp_val);
      end
      if (prev == 4'b1000 && gray_wr_ptr == 4'b0000) wraps++;
      gray_rd_ptr = g4(m_wr - 2);
      for (int t = 0; t < 4; t++) begin
        checks++;
        if (wr_level > 4'd3 || wr_full !== 1'b0) begin
          errors++;
          $display("FAIL wrap_bound[%0d]: got lvl=%0d full=%b required lvl<=3 full=0", n, wr_level, wr_full);
        end
        if (t < 3) tick();
      end
      checks++;
      if (wr_level !== 4'd2) begin
        errors++;
        $display("FAIL wrap_settle[%0d]: got lvl=%0d required 2", n, wr_level);
      end
    end
    checks++;
    if (wraps < 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d required >=2", wraps);
    end
  endtask

  task automatic test_reset_burst();
    for (int i = 0; i < 3; i++) begin
      wr_inc = 1'b1;
      exp_q.push_back(g4(m_wr + 1));
      tick();
      m_wr++;
      pop_exp(exp_val);
      checks++;
      if (gray_wr_ptr !== exp_val) begin
        errors++;
        $display("FAIL burst_gray[%0d]: got %b required %b", i, gray_wr_ptr, exp_val);
      end
    end
    // fourth write is interrupted by reset
    #2 W_RST = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b0 || gray_wr_ptr !== 4'b0000 || wr_overflow !== 1'b0 || wr_level !== 4'd0) begin
      errors++;
      $display("FAIL burst_reset: got en=%b gray=%b ovf=%b lvl=%0d required 0/0000/0/0",
               wr_en, gray_wr_ptr, wr_overflow, wr_level);
    end
    tick();
    checks++;
    if (gray_wr_ptr !== 4'b0000) begin
      errors++;
      $display("FAIL burst_reset_hold: got %b required 0000", gray_wr_ptr);
    end
    wr_inc = 1'b0;
    gray_rd_ptr = 4'b0000;
    W_RST = 1'b0;
    exp_q.delete();
    m_wr = 0;
    tick();
    test_fill();
  endtask

  initial begin
    gold_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    W_RST = 1'b1;
    wr_inc = 1'b0;
    gray_rd_ptr = 4'b0000;
    m_wr = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_reset_burst();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
